id_ex_stage: RTL and testbench

ID/EX pipeline stage of the pipelined RISC-V core, sitting directly upstream of the ALU. It registers the decoded instruction and holds or bubbles it under stall and flush control. It resolves both ALU operands with EX/MEM and MEM/WB forwarding and drives `ALUoprand1`, `ALUoprand2` and `ALUOP` straight into the ALU. It also detects load-use hazards and tells decode to hold.

---
 rtl/id_ex_stage_if.sv | 62 ++++++
 rtl/id_ex_stage.sv | 105 ++++++++++
 tb/tb_id_ex_stage.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode inputs, forwarding sources and the EX-side outputs.
interface id_ex_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RW   = 5
);
    logic            Stall;
    logic            Flush;
    logic            id_valid;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [RW-1:0]   id_rs1;
    logic [RW-1:0]   id_rs2;
    logic [RW-1:0]   id_rd;
    logic [2:0]      id_ALUOP;
    logic            id_ALUSrc;
    logic            id_RegWrite;
    logic            id_MemRead;
    logic            id_MemWrite;
    logic            id_MemtoReg;
    logic [RW-1:0]   exmem_rd;
    logic            exmem_RegWrite;
    logic [XLEN-1:0] exmem_result;
    logic [RW-1:0]   memwb_rd;
    logic            memwb_RegWrite;
    logic [XLEN-1:0] memwb_result;
    logic [XLEN-1:0] ALUoprand1;
    logic [XLEN-1:0] ALUoprand2;
    logic [2:0]      ALUOP;
    logic            ex_valid;
    logic            ex_RegWrite;
    logic            ex_MemRead;
    logic            ex_MemWrite;
    logic            ex_MemtoReg;
    logic [RW-1:0]   ex_rd;
    logic [XLEN-1:0] ex_store_data;
    logic            LoadUseStall;

    // Driven by the surrounding pipeline (or a testbench).
    modport master (
        output Stall, Flush, id_valid, id_rs1_data, id_rs2_data, id_imm,
        output id_rs1, id_rs2, id_rd, id_ALUOP, id_ALUSrc, id_RegWrite,
        output id_MemRead, id_MemWrite, id_MemtoReg,
        output exmem_rd, exmem_RegWrite, exmem_result,
        output memwb_rd, memwb_RegWrite, memwb_result,
        input  ALUoprand1, ALUoprand2, ALUOP, ex_valid, ex_RegWrite,
        input  ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_rd, ex_store_data,
        input  LoadUseStall
    );

    // Used by the ID/EX stage itself.
    modport slave (
        input  Stall, Flush, id_valid, id_rs1_data, id_rs2_data, id_imm,
        input  id_rs1, id_rs2, id_rd, id_ALUOP, id_ALUSrc, id_RegWrite,
        input  id_MemRead, id_MemWrite, id_MemtoReg,
        input  exmem_rd, exmem_RegWrite, exmem_result,
        input  memwb_rd, memwb_RegWrite, memwb_result,
        output ALUoprand1, ALUoprand2, ALUOP, ex_valid, ex_RegWrite,
        output ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_rd, ex_store_data,
        output LoadUseStall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
module id_ex_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RW   = 5
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic            valid;
        logic            alusrc;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic [2:0]      aluop;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
    } ex_fields_t;

    ex_fields_t      r_ex;
    ex_fields_t      w_ex_d;
    ex_fields_t      w_id;
    logic            w_load_use;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // Pack the decode-side fields into one record.
    always_comb begin
        w_id          = '0;
        w_id.valid    = bus.id_valid;
        w_id.alusrc   = bus.id_ALUSrc;
        w_id.regwrite = bus.id_RegWrite;
        w_id.memread  = bus.id_MemRead;
        w_id.memwrite = bus.id_MemWrite;
        w_id.memtoreg = bus.id_MemtoReg;
        w_id.aluop    = bus.id_ALUOP;
        w_id.rs1      = bus.id_rs1;
        w_id.rs2      = bus.id_rs2;
        w_id.rd       = bus.id_rd;
        w_id.rs1_data = bus.id_rs1_data;
        w_id.rs2_data = bus.id_rs2_data;
        w_id.imm      = bus.id_imm;
    end

    // A load in EX whose destination is read by decode; rs2 is checked even if unused.
    assign w_load_use = r_ex.valid & r_ex.memread & (r_ex.rd != '0) & bus.id_valid &
                        ((r_ex.rd == bus.id_rs1) | (r_ex.rd == bus.id_rs2));

    // Next-state: flush beats stall, stall beats the load-use bubble.
    always_comb begin
        w_ex_d = w_id;
        if (bus.Flush) begin
            w_ex_d = '0;
        end else if (bus.Stall) begin
            w_ex_d = r_ex;
        end else if (w_load_use) begin
            w_ex_d = '0;
        end
    end

    // Pipeline register; reset loads a bubble immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else begin
            r_ex <= w_ex_d;
        end
    end

    // Operand forwarding: EX/MEM beats MEM/WB, x0 is never forwarded.
    always_comb begin
        w_fwd_rs1 = r_ex.rs1_data;
        if (bus.exmem_RegWrite && (bus.exmem_rd != '0) && (bus.exmem_rd == r_ex.rs1)) begin
            w_fwd_rs1 = bus.exmem_result;
        end else if (bus.memwb_RegWrite && (bus.memwb_rd != '0) &&
                     (bus.memwb_rd == r_ex.rs1)) begin
            w_fwd_rs1 = bus.memwb_result;
        end
        w_fwd_rs2 = r_ex.rs2_data;
        if (bus.exmem_RegWrite && (bus.exmem_rd != '0) && (bus.exmem_rd == r_ex.rs2)) begin
            w_fwd_rs2 = bus.exmem_result;
        end else if (bus.memwb_RegWrite && (bus.memwb_rd != '0) &&
                     (bus.memwb_rd == r_ex.rs2)) begin
            w_fwd_rs2 = bus.memwb_result;
        end
    end

    assign bus.ALUoprand1    = w_fwd_rs1;
    assign bus.ALUoprand2    = r_ex.alusrc ? r_ex.imm : w_fwd_rs2;
    assign bus.ex_store_data = w_fwd_rs2;
    assign bus.ALUOP         = r_ex.aluop;
    assign bus.ex_valid      = r_ex.valid;
    assign bus.ex_RegWrite   = r_ex.regwrite;
    assign bus.ex_MemRead    = r_ex.memread;
    assign bus.ex_MemWrite   = r_ex.memwrite;
    assign bus.ex_MemtoReg   = r_ex.memtoreg;
    assign bus.ex_rd         = r_ex.rd;
    assign bus.LoadUseStall  = w_load_use;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed plan steps then randomized traffic.
module tb_id_ex_stage;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    id_ex_stage_if #(.XLEN(32), .RW(5)) bus ();

    id_ex_stage #(.XLEN(32), .RW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction currently sitting in EX.
    typedef struct {
        bit        valid, alusrc, regwrite, memread, memwrite, memtoreg;
        bit [2:0]  aluop;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] d1, d2, imm;
    } instr_t;

    instr_t m_ex;

    function automatic instr_t bubble();
        instr_t b;
        b = '{default: 0};
        return b;
    endfunction

    function automatic instr_t from_id();
        instr_t t;
        t.valid = bus.id_valid;       t.alusrc = bus.id_ALUSrc;
        t.regwrite = bus.id_RegWrite; t.memread = bus.id_MemRead;
        t.memwrite = bus.id_MemWrite; t.memtoreg = bus.id_MemtoReg;
        t.aluop = bus.id_ALUOP;
        t.rs1 = bus.id_rs1; t.rs2 = bus.id_rs2; t.rd = bus.id_rd;
        t.d1 = bus.id_rs1_data; t.d2 = bus.id_rs2_data; t.imm = bus.id_imm;
        return t;
    endfunction

    // Value a register read in EX should see given the current forwarding sources.
    function automatic bit [31:0] fwd(bit [4:0] r, bit [31:0] d);
        if (bus.exmem_RegWrite && bus.exmem_rd != 0 && bus.exmem_rd == r) return bus.exmem_result;
        if (bus.memwb_RegWrite && bus.memwb_rd != 0 && bus.memwb_rd == r) return bus.memwb_result;
        return d;
    endfunction

    function automatic bit exp_lus();
        return m_ex.valid && m_ex.memread && m_ex.rd != 0 && bus.id_valid &&
               (m_ex.rd == bus.id_rs1 || m_ex.rd == bus.id_rs2);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        bit [31:0] e2;
        e2 = m_ex.alusrc ? m_ex.imm : fwd(m_ex.rs2, m_ex.d2);
        chk({tag, ".op1"},   bus.ALUoprand1, fwd(m_ex.rs1, m_ex.d1));
        chk({tag, ".op2"},   bus.ALUoprand2, e2);
        chk({tag, ".store"}, bus.ex_store_data, fwd(m_ex.rs2, m_ex.d2));
        chk({tag, ".aluop"}, 32'(bus.ALUOP), 32'(m_ex.aluop));
        chk({tag, ".ctl"},
            {27'd0, bus.ex_valid, bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite,
             bus.ex_MemtoReg},
            {27'd0, m_ex.valid, m_ex.regwrite, m_ex.memread, m_ex.memwrite, m_ex.memtoreg});
        chk({tag, ".rd"},    32'(bus.ex_rd), 32'(m_ex.rd));
        chk({tag, ".lus"},   32'(bus.LoadUseStall), 32'(exp_lus()));
    endtask

    // Check outputs, then advance one edge and update the model from the spec's priority rules.
    task automatic cycle(string tag);
        instr_t nxt;
        #1;
        check_all(tag);
        if (bus.Flush)      nxt = bubble();
        else if (bus.Stall) nxt = m_ex;
        else if (exp_lus()) nxt = bubble();
        else                nxt = from_id();
        @(posedge clk);
        m_ex = nxt;
        @(negedge clk);
    endtask

    task automatic set_id(bit v, bit [4:0] rs1, bit [4:0] rs2, bit [4:0] rd,
                          bit [31:0] d1, bit [31:0] d2, bit [31:0] imm, bit [2:0] op,
                          bit alusrc, bit regwrite, bit memread);
        bus.id_valid = v;  bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm; bus.id_ALUOP = op;
        bus.id_ALUSrc = alusrc; bus.id_RegWrite = regwrite; bus.id_MemRead = memread;
        bus.id_MemWrite = 1'b0; bus.id_MemtoReg = memread;
    endtask

    task automatic set_fwd(bit [4:0] er, bit ew, bit [31:0] ed,
                           bit [4:0] mr, bit mw, bit [31:0] md);
        bus.exmem_rd = er; bus.exmem_RegWrite = ew; bus.exmem_result = ed;
        bus.memwb_rd = mr; bus.memwb_RegWrite = mw; bus.memwb_result = md;
    endtask

    task automatic rand_inputs();
        bus.Stall = ($urandom_range(0, 5) == 0);
        bus.Flush = ($urandom_range(0, 9) == 0);
        set_id(1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 3'($urandom),
               1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
        bus.id_MemWrite = 1'($urandom);
        set_fwd(5'($urandom_range(0, 7)), 1'($urandom), $urandom,
                5'($urandom_range(0, 7)), 1'($urandom), $urandom);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_ex    = bubble();
        rst_n   = 1'b0;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);

        // Reset state: everything zero.
        #2;
        check_all("reset");
        chk("reset.op1_zero", bus.ALUoprand1, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic pass-through: 5 and 7 reach the ALU one cycle later.
        set_id(1'b1, 5'd1, 5'd2, 5'd10, 32'd5, 32'd7, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0);
        cycle("basic_load");
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("basic.op1", bus.ALUoprand1, 32'd5);
        chk("basic.op2", bus.ALUoprand2, 32'd7);
        chk("basic.valid", 32'(bus.ex_valid), 32'd1);
        cycle("basic_out");

        // Forwarding priority on rs1 = x3; stall holds EX while sources change.
        set_id(1'b1, 5'd3, 5'd4, 5'd6, 32'h1111, 32'h2222, 32'd0, 3'b010, 1'b0, 1'b1, 1'b0);
        cycle("fwd_load");
        bus.Stall = 1'b1;
        set_fwd(5'd3, 1'b1, 32'h10, 5'd3, 1'b1, 32'h20);
        #1;
        chk("fwd.exmem_wins", bus.ALUoprand1, 32'h10);
        cycle("fwd_both");
        bus.exmem_RegWrite = 1'b0;
        #1;
        chk("fwd.memwb", bus.ALUoprand1, 32'h20);
        cycle("fwd_memwb");
        bus.Stall = 1'b0;
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 32'hABC, 32'hDEF, 32'd0, 3'b001, 1'b0, 1'b1, 1'b0);
        cycle("x0_load");
        set_fwd(5'd0, 1'b1, 32'h10, 5'd0, 1'b1, 32'h20);
        #1;
        chk("fwd.x0_op1", bus.ALUoprand1, 32'hABC);
        chk("fwd.x0_op2", bus.ALUoprand2, 32'hDEF);
        cycle("x0_check");

        // Immediate operand vs forwarded store data.
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
        set_id(1'b1, 5'd1, 5'd4, 5'd0, 32'd3, 32'd1, 32'hFFFF_FFFC, 3'b000, 1'b1, 1'b0, 1'b0);
        cycle("imm_load");
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        set_fwd(5'd4, 1'b1, 32'd9, 5'd0, 1'b0, 32'd0);
        #1;
        chk("imm.op2", bus.ALUoprand2, 32'hFFFF_FFFC);
        chk("imm.store", bus.ex_store_data, 32'd9);
        cycle("imm_check");
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);

        // Load-use: lw x5 in EX, add reads x5 as rs2.
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'd0, 32'd0, 32'd8, 3'b000, 1'b1, 1'b1, 1'b1);
        cycle("lw_load");
        set_id(1'b1, 5'd6, 5'd5, 5'd7, 32'd1, 32'd2, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0);
        #1;
        chk("lu.stall", 32'(bus.LoadUseStall), 32'd1);
        cycle("lu_hazard");
        #1;
        chk("lu.bubble_valid", 32'(bus.ex_valid), 32'd0);
        chk("lu.one_cycle", 32'(bus.LoadUseStall), 32'd0);
        cycle("lu_after");
        // Same shape with rd = x0: no hazard.
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'd8, 3'b000, 1'b1, 1'b1, 1'b1);
        cycle("lw0_load");
        set_id(1'b1, 5'd6, 5'd0, 5'd7, 32'd1, 32'd2, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0);
        #1;
        chk("lu.x0", 32'(bus.LoadUseStall), 32'd0);
        cycle("lu_x0");

        // Stall for three edges, then Stall+Flush together.
        set_id(1'b1, 5'd1, 5'd2, 5'd9, 32'h55, 32'h66, 32'd0, 3'b101, 1'b0, 1'b1, 1'b0);
        cycle("stall_load");
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'd11, 5'd12, 5'd13, $urandom, $urandom, $urandom, 3'b111,
                   1'b1, 1'b0, 1'b0);
            #1;
            chk("stall.op1", bus.ALUoprand1, 32'h55);
            chk("stall.aluop", 32'(bus.ALUOP), 32'b101);
            cycle("stall_hold");
        end
        bus.Flush = 1'b1;
        cycle("stall_flush");
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        #1;
        chk("flush.valid", 32'(bus.ex_valid), 32'd0);
        chk("flush.rd", 32'(bus.ex_rd), 32'd0);

        // Asynchronous reset between edges.
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h77, 32'h88, 32'd0, 3'b011, 1'b0, 1'b1, 1'b0);
        cycle("mid_load");
        #2;
        rst_n = 1'b0;
        #1;
        m_ex = bubble();
        chk("mid_rst.op1", bus.ALUoprand1, 32'd0);
        chk("mid_rst.valid", 32'(bus.ex_valid), 32'd0);
        check_all("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
